// File: rtl/corelet_ws_ctrl.sv
// corelet_ws_ctrl: weight-stationary job sequencer (kernel fetch/load, flush, execute, psum drain).
// Define CORELET_CTRL_PERF_EN to add the cyc_cnt/stall_cnt performance counter ports.
module corelet_ws_ctrl #(
    parameter int col        = 8,
    parameter int row        = 8,
    parameter int addr_width = 8,
    parameter int len_onij   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_width-1:0] w_base,
    input  logic [addr_width-1:0] x_base,
    input  logic [addr_width-1:0] p_base,
    output logic                  busy,
    output logic                  done,
    output logic                  wmem_cen,
    output logic                  xmem_cen,
    output logic [addr_width-1:0] mem_addr,
    output logic                  bank_sel,
    output logic                  l0_wr_en,
    output logic                  l0_rd_en,
    input  logic                  l0_wr_ready,
    input  logic                  l0_rd_ready,
    output logic [1:0]            inst,
    output logic                  w_overwrite,
    input  logic                  d_valid,
    output logic                  psum_wen,
    output logic [addr_width-1:0] psum_addr
`ifdef CORELET_CTRL_PERF_EN
    ,
    output logic [31:0]           cyc_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int CNT_W = $clog2((col > len_onij ? col : len_onij) + 1);
    localparam int FL_W  = $clog2(row + col + 1);
    localparam logic [CNT_W-1:0] COL_N      = CNT_W'(col);
    localparam logic [CNT_W-1:0] LEN_N      = CNT_W'(len_onij);
    localparam logic [CNT_W-1:0] COL_LAST   = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0] LEN_LAST   = CNT_W'(len_onij - 1);
    localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(row + col - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_W_LOAD, S_W_FLUSH, S_EXEC, S_DRAIN, S_DONE
    } state_t;

    state_t                r_state;
    logic [addr_width-1:0] r_addr;
    logic [addr_width-1:0] r_x_base;
    logic [addr_width-1:0] r_p_base;
    logic [CNT_W-1:0]      r_fetch_cnt;
    logic [CNT_W-1:0]      r_pop_cnt;
    logic [CNT_W-1:0]      r_psum_cnt;
    logic [FL_W-1:0]       r_flush_cnt;
    logic                  r_rd_issued;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_bank_sel;
    logic                  r_w_overwrite;

    logic                  w_streaming;
    logic [CNT_W-1:0]      w_target;
    logic [CNT_W-1:0]      w_last;
    logic                  w_fetch_want;
    logic                  w_fetch;
    logic                  w_pop;
    logic                  w_pop_last;
    logic                  w_collect;
    logic                  w_psum_last;

    // NOTE: the L0 and psum handshakes are decoded from registered state plus the
    // current ready/valid inputs; registering them would act on stale readiness and
    // could pop an empty L0 or push into a full one.
    assign w_streaming  = (r_state == S_W_LOAD) || (r_state == S_EXEC);
    assign w_target     = (r_state == S_EXEC) ? LEN_N : COL_N;
    assign w_last       = (r_state == S_EXEC) ? LEN_LAST : COL_LAST;
    assign w_fetch_want = w_streaming && (r_fetch_cnt < w_target);
    assign w_fetch      = w_fetch_want && l0_wr_ready && !r_rd_issued;
    assign w_pop        = w_streaming && l0_rd_ready && (r_pop_cnt < w_target);
    assign w_pop_last   = w_pop && (r_pop_cnt == w_last);
    assign w_collect    = ((r_state == S_EXEC) || (r_state == S_DRAIN)) && d_valid
                          && (r_psum_cnt < LEN_N);
    assign w_psum_last  = w_collect && (r_psum_cnt == LEN_LAST);

    assign busy        = r_busy;
    assign done        = r_done;
    assign bank_sel    = r_bank_sel;
    assign w_overwrite = r_w_overwrite;
    assign mem_addr    = r_addr;
    assign wmem_cen    = w_fetch && (r_state == S_W_LOAD);
    assign xmem_cen    = w_fetch && (r_state == S_EXEC);
    assign l0_wr_en    = r_rd_issued;
    assign l0_rd_en    = w_pop;
    assign inst        = !w_pop ? 2'b00 : ((r_state == S_EXEC) ? 2'b10 : 2'b01);
    assign psum_wen    = w_collect;
    assign psum_addr   = r_p_base + addr_width'(r_psum_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_x_base      <= '0;
            r_p_base      <= '0;
            r_fetch_cnt   <= '0;
            r_pop_cnt     <= '0;
            r_psum_cnt    <= '0;
            r_flush_cnt   <= '0;
            r_rd_issued   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_bank_sel    <= 1'b0;
            r_w_overwrite <= 1'b0;
        end else begin
            r_rd_issued <= w_fetch;
            r_done      <= 1'b0;
            if (w_fetch) begin
                r_addr      <= r_addr + 1'b1;
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end
            if (w_pop)     r_pop_cnt  <= r_pop_cnt + 1'b1;
            if (w_collect) r_psum_cnt <= r_psum_cnt + 1'b1;

            // Phase changes below override the per-cycle counter updates above.
            case (r_state)
                S_IDLE: if (start) begin
                    r_state       <= S_W_LOAD;
                    r_addr        <= w_base;
                    r_x_base      <= x_base;
                    r_p_base      <= p_base;
                    r_fetch_cnt   <= '0;
                    r_pop_cnt     <= '0;
                    r_psum_cnt    <= '0;
                    r_busy        <= 1'b1;
                    r_bank_sel    <= 1'b0;
                    r_w_overwrite <= 1'b1;
                end
                S_W_LOAD: if (w_pop_last) begin
                    r_state       <= S_W_FLUSH;
                    r_flush_cnt   <= '0;
                    r_w_overwrite <= 1'b0;
                end
                S_W_FLUSH: begin
                    if (r_flush_cnt == FLUSH_LAST) begin
                        r_state     <= S_EXEC;
                        r_addr      <= r_x_base;
                        r_fetch_cnt <= '0;
                        r_pop_cnt   <= '0;
                        r_bank_sel  <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end
                S_EXEC: if (w_pop_last) r_state <= S_DRAIN;
                S_DRAIN: if (w_psum_last || (r_psum_cnt == LEN_N)) begin
                    r_state    <= S_DONE;
                    r_done     <= 1'b1;
                    r_bank_sel <= 1'b0;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CORELET_CTRL_PERF_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cyc_cnt   <= '0;
            r_stall_cnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_cyc_cnt   <= '0;
            r_stall_cnt <= '0;
        end else if (r_state != S_IDLE) begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
            if (w_fetch_want && !l0_wr_ready) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign cyc_cnt   = r_cyc_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_corelet_ws_ctrl.sv
// Self-checking bench for corelet_ws_ctrl: L0 occupancy model, address scoreboards, directed jobs.
module tb_corelet_ws_ctrl;
    localparam int COL = 8;
    localparam int ROW = 8;
    localparam int AW  = 8;
    localparam int LEN = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] w_base, x_base, p_base;
    logic          busy, done, wmem_cen, xmem_cen;
    logic [AW-1:0] mem_addr;
    logic          bank_sel, l0_wr_en, l0_rd_en;
    logic          l0_wr_ready, l0_rd_ready;
    logic [1:0]    inst;
    logic          w_overwrite;
    logic          d_valid;
    logic          psum_wen;
    logic [AW-1:0] psum_addr;
`ifdef CORELET_CTRL_PERF_EN
    logic [31:0]   cyc_cnt, stall_cnt;
`endif

    corelet_ws_ctrl #(.col(COL), .row(ROW), .addr_width(AW), .len_onij(LEN)) dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .x_base(x_base), .p_base(p_base),
        .busy(busy), .done(done), .wmem_cen(wmem_cen), .xmem_cen(xmem_cen),
        .mem_addr(mem_addr), .bank_sel(bank_sel),
        .l0_wr_en(l0_wr_en), .l0_rd_en(l0_rd_en),
        .l0_wr_ready(l0_wr_ready), .l0_rd_ready(l0_rd_ready),
        .inst(inst), .w_overwrite(w_overwrite), .d_valid(d_valid),
        .psum_wen(psum_wen), .psum_addr(psum_addr)
`ifdef CORELET_CTRL_PERF_EN
        , .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [AW-1:0] w_q[$];
    logic [AW-1:0] x_q[$];
    logic [AW-1:0] p_q[$];

    int occ, stall_left, jobs;
    bit stall_arm;
    int pops, exec_pops, w_reads, x_reads, psum_cnt, dv_sent, busy_cycles;
    int last_wpop, last_wcen, last_xcen, last_psum, done_cyc;
    bit done_seen, prev_busy, prev_done, s_wr, s_rd, s_start;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic start_job();
        check("start_high_at_accept", 32'(s_start), 1);
        for (int i = 0; i < COL; i++) w_q.push_back(w_base + AW'(i));
        for (int i = 0; i < LEN; i++) x_q.push_back(x_base + AW'(i));
        for (int i = 0; i < LEN; i++) p_q.push_back(p_base + AW'(i));
        pops = 0; exec_pops = 0; w_reads = 0; x_reads = 0; psum_cnt = 0;
        dv_sent = 0; busy_cycles = 0; done_seen = 0;
        jobs++;
    endtask

    task automatic end_job();
        check("w_reads_all", 32'(w_q.size()), 0);
        check("x_reads_all", 32'(x_q.size()), 0);
        check("psum_all", 32'(p_q.size()), 0);
        check("pop_total", 32'(pops), COL + LEN);
        check("busy_drop_after_done", 32'(cyc - done_cyc), 1);
    endtask

    // One clock: update the L0/SFP environment after the edge, then sample and score outputs.
    task automatic cycle();
        logic [31:0] exp;
        s_start = start;
        @(posedge clk);
        #1;
        if (s_wr) occ++;
        if (s_rd) occ--;
        l0_wr_ready = (occ < 4) && (stall_left == 0);
        l0_rd_ready = (occ > 0);
        if (stall_left > 0) stall_left--;
        d_valid = (exec_pops > dv_sent) && (cyc % 3 != 1);
        if (d_valid) dv_sent++;
        #1;
        cyc++;

        if (busy && !prev_busy) start_job();
        if (busy) busy_cycles++;
        if (prev_done) check("idle_after_done", 32'(busy), 0);

        if (wmem_cen) begin
            exp = (w_q.size() > 0) ? 32'(w_q.pop_front()) : 32'hDEAD;
            check("w_addr", 32'(mem_addr), exp);
            check("w_bank_sel", 32'(bank_sel), 0);
            if (w_reads > 0) check("w_alternate", 32'(cyc - last_wcen), 2);
            last_wcen = cyc;
            w_reads++;
        end
        if (xmem_cen) begin
            exp = (x_q.size() > 0) ? 32'(x_q.pop_front()) : 32'hDEAD;
            check("x_addr", 32'(mem_addr), exp);
            check("x_bank_sel", 32'(bank_sel), 1);
            if (x_reads == 0) check("flush_then_exec", 32'(cyc - last_wpop), ROW + COL + 1);
            else check("x_no_back_to_back", 32'(cyc - last_xcen >= 2), 1);
            last_xcen = cyc;
            x_reads++;
            if (stall_arm && x_reads == 6) begin
                stall_left = 5;
                stall_arm  = 0;
            end
        end
        if (!l0_wr_ready) check("no_fetch_when_full", 32'(wmem_cen | xmem_cen), 0);

        if (l0_rd_en) begin
            pops++;
            if (pops <= COL) begin
                check("inst_kernel", 32'(inst), 1);
                check("w_overwrite", 32'(w_overwrite), 1);
                if (pops == COL) last_wpop = cyc;
            end else begin
                check("inst_exec", 32'(inst), 2);
                exec_pops++;
            end
        end else if (busy) begin
            check("inst_idle", 32'(inst), 0);
        end

        if (psum_wen) begin
            exp = (p_q.size() > 0) ? 32'(p_q.pop_front()) : 32'hDEAD;
            check("psum_addr", 32'(psum_addr), exp);
            psum_cnt++;
            if (psum_cnt == LEN) last_psum = cyc;
        end
        if (done) begin
            check("done_latency", 32'(cyc - last_psum), 1);
            check("done_with_busy", 32'(busy), 1);
            done_seen = 1;
            done_cyc  = cyc;
        end
        if (!busy && prev_busy) end_job();

        prev_busy = busy;
        prev_done = done;
        s_wr = l0_wr_en;
        s_rd = l0_rd_en;
    endtask

    task automatic wait_job(input int budget);
        for (int i = 0; i < budget && !(done_seen && !busy); i++) cycle();
        check("job_finished_in_budget", 32'(done_seen && !busy), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_cen"}, 32'({wmem_cen, xmem_cen}), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_bank_sel"}, 32'(bank_sel), 0);
        check({tag, "_l0_en"}, 32'({l0_wr_en, l0_rd_en}), 0);
        check({tag, "_inst"}, 32'(inst), 0);
        check({tag, "_w_overwrite"}, 32'(w_overwrite), 0);
        check({tag, "_psum"}, 32'({psum_wen, psum_addr}), 0);
    endtask

    task automatic env_clear();
        occ = 0; stall_left = 0; stall_arm = 0;
        s_wr = 0; s_rd = 0; prev_busy = 0; prev_done = 0;
        pops = 0; exec_pops = 0; dv_sent = 0; done_seen = 0;
        w_q.delete(); x_q.delete(); p_q.delete();
        d_valid = 0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; d_valid = 1'b0;
        w_base = '0; x_base = '0; p_base = '0;
        l0_wr_ready = 1'b0; l0_rd_ready = 1'b0;
        jobs = 0; last_wpop = 0; last_wcen = 0; last_xcen = 0; last_psum = 0; done_cyc = 0;
        env_clear();
        repeat (2) cycle();
        check_all_zero("reset");
        reset = 1'b0;
        cycle();

        // Reset in the middle of EXEC aborts the job.
        w_base = 8'h10; x_base = 8'h40; p_base = 8'hF8;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 300 && x_reads < 3; i++) cycle();
        check("reached_exec", 32'(x_reads >= 3), 1);
        #2 reset = 1'b1;
        #1 check_all_zero("abort");
        env_clear();
        repeat (2) cycle();
        reset = 1'b0;
        cycle();

        // Clean job: kernel at 0x10, activations at 0x40, psum wrapping from 0xF8.
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_job(400);
`ifdef CORELET_CTRL_PERF_EN
        check("cyc_cnt_clean", cyc_cnt, 32'(busy_cycles));
        check("stall_cnt_clean", stall_cnt, 0);
`endif
        repeat (3) cycle();

        // L0 not ready for 5 cycles in the middle of EXEC.
        w_base = 8'h20; x_base = 8'h40; p_base = 8'h00;
        stall_arm = 1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_job(400);
        check("stall_applied", 32'(stall_arm), 0);
`ifdef CORELET_CTRL_PERF_EN
        check("stall_cnt", stall_cnt, 5);
        check("cyc_cnt", cyc_cnt, 32'(busy_cycles));
`endif
        repeat (3) cycle();

        // Start held high: second job only after the first returns to IDLE.
        w_base = 8'h30; x_base = 8'h60; p_base = 8'h80;
        start = 1'b1;
        cycle();
        check("held_start_accept", 32'(busy), 1);
        w_base = 8'h50; x_base = 8'h70; p_base = 8'h90;
        wait_job(400);
        cycle();
        check("restart_from_idle", 32'(busy), 1);
        start = 1'b0;
        wait_job(400);
        repeat (3) cycle();
        check("job_count", 32'(jobs), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
